// File: rtl/pipe_mips32_fwd.sv
// pipe_mips32_fwd - single-clock 5-stage MIPS32 pipeline (IF/ID/EX/MEM/WB).
// The design has full forwarding into EX, a one-cycle load-use interlock and a
// taken-branch flush that is resolved in EX. Instruction and data share one memory.
// Ports:
//   clk, rst             sole clock; synchronous active-high reset
//   prog_we/addr/data    memory write port, honoured only while rst=1
//   dbg_raddr/dbg_rdata  combinational register-file read
//   halted               sticky, set the cycle after HLT retires
//   instret              count of instructions retired in WB (HLT included), wraps
module pipe_mips32_fwd #(
  parameter int MEM_AW = 10,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [MEM_AW-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic [4:0]        dbg_raddr,
  output logic [31:0]       dbg_rdata,
  output logic              halted,
  output logic [CNT_W-1:0]  instret
);
  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02, OP_OR = 6'h03,
                         OP_SLT = 6'h04, OP_MUL = 6'h05, OP_LW = 6'h08, OP_SW = 6'h09,
                         OP_ADDI = 6'h0a, OP_SUBI = 6'h0b, OP_SLTI = 6'h0c,
                         OP_BNEQZ = 6'h0d, OP_BEQZ = 6'h0e, OP_HLT = 6'h3f;

  typedef struct packed {
    logic              v;
    logic [MEM_AW-1:0] pc;
    logic [31:0]       ir;
  } ifid_t;

  typedef struct packed {
    logic              v;
    logic [5:0]        op;
    logic [MEM_AW-1:0] pc;
    logic [4:0]        rs, rt, dst;   // dst=0 means "writes no register"
    logic [31:0]       a, b, imm;
  } idex_t;

  typedef struct packed {
    logic        v;
    logic [5:0]  op;
    logic [4:0]  dst;
    logic [31:0] alu, b;
  } exmem_t;

  typedef struct packed {
    logic        v;
    logic [5:0]  op;
    logic [4:0]  dst;
    logic [31:0] res;
  } memwb_t;

  logic [31:0]       mem [2**MEM_AW];
  logic [31:0]       rf  [32];
  logic [MEM_AW-1:0] pc;
  logic              stop;            // HLT has passed ID: fetch only bubbles
  ifid_t             ifid;
  idex_t             idex, id_nxt;
  exmem_t            exmem;
  memwb_t            memwb;

  // ---------------- ID: decode, register read, hazard detect ----------------
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_rr, id_use_rs, id_use_rt, id_wr_rt, wb_we;
  logic [31:0] id_a, id_b;
  logic        ld_use, hlt_id;

  assign id_op     = ifid.ir[31:26];
  assign id_rs     = ifid.ir[25:21];
  assign id_rt     = ifid.ir[20:16];
  assign id_rd     = ifid.ir[15:11];
  assign id_rr     = (id_op <= OP_MUL);
  assign id_wr_rt  = (id_op == OP_LW) || (id_op == OP_ADDI) || (id_op == OP_SUBI) ||
                     (id_op == OP_SLTI);
  assign id_use_rs = id_rr || id_wr_rt || (id_op == OP_SW) || (id_op == OP_BNEQZ) ||
                     (id_op == OP_BEQZ);
  assign id_use_rt = id_rr || (id_op == OP_SW);
  assign wb_we     = memwb.v && (memwb.dst != 5'd0);

  // Write-first: the value retiring this cycle bypasses the array.
  always_comb begin
    id_a = rf[id_rs];
    id_b = rf[id_rt];
    if (wb_we && memwb.dst == id_rs) id_a = memwb.res;
    if (wb_we && memwb.dst == id_rt) id_b = memwb.res;
    if (id_rs == 5'd0) id_a = '0;
    if (id_rt == 5'd0) id_b = '0;
  end

  always_comb begin
    id_nxt     = '0;
    id_nxt.v   = ifid.v;
    id_nxt.op  = id_op;
    id_nxt.pc  = ifid.pc;
    id_nxt.rs  = id_rs;
    id_nxt.rt  = id_rt;
    id_nxt.dst = id_rr ? id_rd : (id_wr_rt ? id_rt : 5'd0);
    id_nxt.a   = id_a;
    id_nxt.b   = id_b;
    id_nxt.imm = {{16{ifid.ir[15]}}, ifid.ir[15:0]};
  end

  // LW's dst is its rt, so a non-zero dst on an LW in EX is the interlock source.
  assign ld_use = idex.v && (idex.op == OP_LW) && (idex.dst != 5'd0) && ifid.v &&
                  ((id_use_rs && id_rs == idex.dst) || (id_use_rt && id_rt == idex.dst));
  assign hlt_id = ifid.v && (id_op == OP_HLT);

  // ---------------- EX: forwarding, ALU, branch ----------------
  logic [31:0]       fa, fb, alu;
  logic              taken;
  logic [MEM_AW-1:0] target;

  // A load in EX/MEM never forwards from there; the interlock guarantees the
  // consumer reaches EX only once the load sits in MEM/WB.
  always_comb begin
    fa = idex.a;
    fb = idex.b;
    if (memwb.v && memwb.dst != 5'd0 && memwb.dst == idex.rs) fa = memwb.res;
    if (memwb.v && memwb.dst != 5'd0 && memwb.dst == idex.rt) fb = memwb.res;
    if (exmem.v && exmem.op != OP_LW && exmem.dst != 5'd0 && exmem.dst == idex.rs)
      fa = exmem.alu;
    if (exmem.v && exmem.op != OP_LW && exmem.dst != 5'd0 && exmem.dst == idex.rt)
      fb = exmem.alu;
  end

  always_comb begin
    case (idex.op)
      OP_ADD:         alu = fa + fb;
      OP_SUB:         alu = fa - fb;
      OP_AND:         alu = fa & fb;
      OP_OR:          alu = fa | fb;
      OP_SLT:         alu = {31'd0, $signed(fa) < $signed(fb)};
      OP_MUL:         alu = fa * fb;
      OP_LW, OP_SW,
      OP_ADDI:        alu = fa + idex.imm;
      OP_SUBI:        alu = fa - idex.imm;
      OP_SLTI:        alu = {31'd0, $signed(fa) < $signed(idex.imm)};
      default:        alu = '0;
    endcase
  end

  assign taken  = idex.v && (((idex.op == OP_BEQZ) && (fa == '0)) ||
                             ((idex.op == OP_BNEQZ) && (fa != '0)));
  assign target = idex.pc + MEM_AW'(1) + idex.imm[MEM_AW-1:0];

  assign dbg_rdata = rf[dbg_raddr];

  // ---------------- memory ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if (prog_we) mem[prog_addr] <= prog_data;
    end else if (!halted && exmem.v && exmem.op == OP_SW) begin
      mem[exmem.alu[MEM_AW-1:0]] <= exmem.b;
    end
  end

  // ---------------- pipeline state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      stop    <= 1'b0;
      ifid    <= '0;
      idex    <= '0;
      exmem   <= '0;
      memwb   <= '0;
      halted  <= 1'b0;
      instret <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!halted) begin
      // WB
      if (wb_we) rf[memwb.dst] <= memwb.res;
      if (memwb.v) instret <= instret + CNT_W'(1);
      if (memwb.v && memwb.op == OP_HLT) halted <= 1'b1;
      // MEM -> WB
      memwb.v   <= exmem.v;
      memwb.op  <= exmem.op;
      memwb.dst <= exmem.dst;
      memwb.res <= (exmem.op == OP_LW) ? mem[exmem.alu[MEM_AW-1:0]] : exmem.alu;
      // EX -> MEM
      exmem.v   <= idex.v;
      exmem.op  <= idex.op;
      exmem.dst <= idex.dst;
      exmem.alu <= alu;
      exmem.b   <= fb;
      // IF/ID -> EX; flush outranks the interlock
      if (taken) begin
        pc     <= target;
        ifid.v <= 1'b0;
        idex.v <= 1'b0;
        stop   <= 1'b0;
      end else if (ld_use) begin
        idex.v <= 1'b0;
      end else begin
        idex <= id_nxt;
        if (hlt_id || stop) begin
          stop   <= 1'b1;
          ifid.v <= 1'b0;
        end else begin
          pc      <= pc + MEM_AW'(1);
          ifid.v  <= 1'b1;
          ifid.pc <= pc;
          ifid.ir <= mem[pc];
        end
      end
    end
  end

endmodule
